// File: rtl/perf_counter_bank_pkg.sv
// Shared constants for the performance-counter bank: default geometry,
// cycle-counter slot and the event channel map used by the core wiring.
package perf_pkg;
  localparam int NUM_EVT_DEF = 8;
  localparam int CNT_W_DEF   = 48;
  localparam int CYC_IDX     = NUM_EVT_DEF;

  localparam int EVT_IFU_VALID = 0;
  localparam int EVT_IC_HIT    = 1;
  localparam int EVT_IC_MISS   = 2;
  localparam int EVT_LSU_RD    = 3;
  localparam int EVT_LSU_WR    = 4;
  localparam int EVT_LSU_WAIT  = 5;
  localparam int EVT_BR_MISS   = 6;
  localparam int EVT_STALL     = 7;

  function automatic int idx_width(input int num_evt);
    return $clog2(num_evt + 1);
  endfunction
endpackage

// File: rtl/perf_counter_bank_if.sv
// Read port of the counter bank: request channel (rd_*) and 1-deep response channel (rsp_*).
interface perf_counter_bank_if #(
  parameter int NUM_EVT = perf_pkg::NUM_EVT_DEF,
  parameter int CNT_W   = perf_pkg::CNT_W_DEF,
  parameter int IDX_W   = perf_pkg::idx_width(NUM_EVT)
);
  // Both channels are valid/ready: a transfer happens on a rising edge where
  // valid && ready; the sender holds valid and its payload stable until then.
  logic             rd_req;
  logic             rd_rdy;
  logic [IDX_W-1:0] rd_idx;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [CNT_W-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output rd_req, rd_idx, rsp_ready,
    input  rd_rdy, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  rd_req, rd_idx, rsp_ready,
    output rd_rdy, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/perf_counter_bank_cell.sv
// One counter slot: live counter with wrap/saturate, sticky overflow flag and snapshot shadow.
module perf_counter_cell import perf_pkg::*; #(
  parameter int CNT_W    = CNT_W_DEF,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             snap,
  output logic [CNT_W-1:0] live,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      live   <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      // Shadow takes the pre-clear, pre-increment value, so snap+clr is an atomic read-and-reset.
      if (snap) shadow <= live;
      if (clr) begin
        live <= '0;
        ovf  <= 1'b0;
      end else if (inc) begin
        if (live == ALL_ONES) begin
          ovf  <= 1'b1;
          live <= SATURATE ? ALL_ONES : '0;
        end else begin
          live <= live + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/perf_counter_bank.sv
// Performance-counter bank: NUM_EVT event counters plus a cycle counter, with
// global enable/clear/snapshot and a valid/ready read port onto the shadow registers.
module perf_counter_bank import perf_pkg::*; #(
  parameter int NUM_EVT  = NUM_EVT_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter bit SATURATE = 1'b0,
  parameter int IDX_W    = idx_width(NUM_EVT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cnt_en,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               clr,
  input  logic               snap,
  perf_counter_bank_if.slave rd,
  output logic [NUM_EVT:0]   ovf
);
  logic [NUM_EVT:0]   inc;
  logic [CNT_W-1:0]   live_unused [NUM_EVT+1];
  logic [CNT_W-1:0]   shadow      [NUM_EVT+1];
  logic [CNT_W-1:0]   sel_data;
  logic               sel_err;
  logic               accept;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [CNT_W-1:0]   rsp_data_q;

  // Top slot is the cycle counter: it counts every enabled cycle.
  assign inc = {(NUM_EVT + 1){cnt_en}} & {1'b1, evt};

  for (genvar i = 0; i <= NUM_EVT; i++) begin : g_cell
    perf_counter_cell #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cell (
      .clk    (clk),
      .reset  (reset),
      .inc    (inc[i]),
      .clr    (clr),
      .snap   (snap),
      .live   (live_unused[i]),
      .shadow (shadow[i]),
      .ovf    (ovf[i])
    );
  end

  assign sel_err = (rd.rd_idx > IDX_W'(NUM_EVT));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (rd.rd_idx == IDX_W'(i)) sel_data = shadow[i];
    end
  end

  assign rd.rd_rdy = !rsp_valid_q || rd.rsp_ready;
  assign accept    = rd.rd_req && rd.rd_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= sel_err;
      rsp_data_q  <= sel_data;
    end else if (rd.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rd.rsp_valid = rsp_valid_q;
  assign rd.rsp_err   = rsp_err_q;
  assign rd.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: three configurations (48-bit wrap, 8-bit wrap,
// 8-bit saturate) driven in lockstep and compared against an arithmetic model.
module tb_perf_counter_bank;
  localparam int NE = 8;
  localparam int IW = $clog2(NE + 1);
  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cnt_en = 1'b0;
  logic          clr = 1'b0;
  logic          snap = 1'b0;
  logic          rd_req = 1'b0;
  logic          rsp_ready = 1'b1;
  logic [NE-1:0] evt = '0;
  logic [IW-1:0] rd_idx = '0;
  logic [NE:0]   ovf0, ovf1, ovf2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  perf_counter_bank_if #(.NUM_EVT(NE), .CNT_W(48)) bus0 ();
  perf_counter_bank_if #(.NUM_EVT(NE), .CNT_W(8))  bus1 ();
  perf_counter_bank_if #(.NUM_EVT(NE), .CNT_W(8))  bus2 ();

  assign bus0.rd_req = rd_req;  assign bus0.rd_idx = rd_idx;  assign bus0.rsp_ready = rsp_ready;
  assign bus1.rd_req = rd_req;  assign bus1.rd_idx = rd_idx;  assign bus1.rsp_ready = rsp_ready;
  assign bus2.rd_req = rd_req;  assign bus2.rd_idx = rd_idx;  assign bus2.rsp_ready = rsp_ready;

  perf_counter_bank #(.NUM_EVT(NE), .CNT_W(48), .SATURATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .cnt_en(cnt_en), .evt(evt), .clr(clr), .snap(snap), .rd(bus0), .ovf(ovf0));
  perf_counter_bank #(.NUM_EVT(NE), .CNT_W(8), .SATURATE(1'b0)) dut1 (
    .clk(clk), .reset(reset), .cnt_en(cnt_en), .evt(evt), .clr(clr), .snap(snap), .rd(bus1), .ovf(ovf1));
  perf_counter_bank #(.NUM_EVT(NE), .CNT_W(8), .SATURATE(1'b1)) dut2 (
    .clk(clk), .reset(reset), .cnt_en(cnt_en), .evt(evt), .clr(clr), .snap(snap), .rd(bus2), .ovf(ovf2));

  logic [63:0] o_data [ND];
  logic        o_rv   [ND];
  logic        o_re   [ND];
  logic        o_rdy  [ND];
  logic [NE:0] o_ovf  [ND];

  assign o_data[0] = 64'(bus0.rsp_data); assign o_rv[0] = bus0.rsp_valid; assign o_re[0] = bus0.rsp_err;
  assign o_data[1] = 64'(bus1.rsp_data); assign o_rv[1] = bus1.rsp_valid; assign o_re[1] = bus1.rsp_err;
  assign o_data[2] = 64'(bus2.rsp_data); assign o_rv[2] = bus2.rsp_valid; assign o_re[2] = bus2.rsp_err;
  assign o_rdy[0] = bus0.rd_rdy; assign o_rdy[1] = bus1.rd_rdy; assign o_rdy[2] = bus2.rd_rdy;
  assign o_ovf[0] = ovf0; assign o_ovf[1] = ovf1; assign o_ovf[2] = ovf2;

  // ---------------- reference model ----------------
  longint unsigned m_live [ND][NE+1];
  longint unsigned m_sh   [ND][NE+1];
  logic [NE:0]     m_ovf  [ND];
  logic            m_rv   [ND];
  logic            m_re   [ND];
  longint unsigned m_rd   [ND];

  function automatic longint unsigned cnt_max(input int d);
    return (d == 0) ? ((64'd1 << 48) - 64'd1) : 64'd255;
  endfunction

  function automatic bit cfg_sat(input int d);
    return d == 2;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (reset) begin
        m_rv[d]  <= 1'b0;
        m_re[d]  <= 1'b0;
        m_rd[d]  <= 0;
        m_ovf[d] <= '0;
        for (int i = 0; i <= NE; i++) begin
          m_live[d][i] <= 0;
          m_sh[d][i]   <= 0;
        end
      end else begin
        if (rd_req && (!m_rv[d] || rsp_ready)) begin
          m_rv[d] <= 1'b1;
          m_re[d] <= (int'(rd_idx) > NE);
          m_rd[d] <= (int'(rd_idx) > NE) ? 64'd0 : m_sh[d][int'(rd_idx)];
        end else if (rsp_ready) begin
          m_rv[d] <= 1'b0;
        end
        if (snap)
          for (int i = 0; i <= NE; i++) m_sh[d][i] <= m_live[d][i];
        if (clr) begin
          m_ovf[d] <= '0;
          for (int i = 0; i <= NE; i++) m_live[d][i] <= 0;
        end else if (cnt_en) begin
          for (int i = 0; i <= NE; i++) begin
            if (i == NE || evt[i]) begin
              if (m_live[d][i] + 1 > cnt_max(d)) begin
                m_ovf[d][i]  <= 1'b1;
                m_live[d][i] <= cfg_sat(d) ? cnt_max(d) : 64'd0;
              end else begin
                m_live[d][i] <= m_live[d][i] + 1;
              end
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_read(input int idx);
    rd_req = 1'b1;
    rd_idx = IW'(idx);
    tick(1);
    rd_req = 1'b0;
  endtask

  task automatic take_snap();
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_rv[d] !== 1'b0 || o_re[d] !== 1'b0 || o_data[d] !== 64'd0 || o_rdy[d] !== 1'b1 || o_ovf[d] !== '0) begin
        fails++;
        $display("FAIL reset d%0d: got valid=%0b err=%0b data=%0h rdy=%0b ovf=%0h, expected 0 0 0 1 0",
                 d, o_rv[d], o_re[d], o_data[d], o_rdy[d], o_ovf[d]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_count();
    cnt_en = 1'b1;
    evt = NE'(1);
    tick(10);
    cnt_en = 1'b0;
    evt = '0;
    take_snap();
    issue_read(0);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_rv[d] !== 1'b1 || o_re[d] !== 1'b0 || o_data[d] !== 64'd10 || o_data[d] !== m_rd[d]) begin
        fails++;
        $display("FAIL basic_evt0 d%0d: got valid=%0b err=%0b data=%0d, expected 1 0 10 (model %0d)",
                 d, o_rv[d], o_re[d], o_data[d], m_rd[d]);
      end
    end
    issue_read(NE);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_rv[d] !== 1'b1 || o_re[d] !== 1'b0 || o_data[d] < 64'd10 || o_data[d] !== m_rd[d]) begin
        fails++;
        $display("FAIL basic_cycles d%0d: got valid=%0b err=%0b data=%0d, expected >=10 (model %0d)",
                 d, o_rv[d], o_re[d], o_data[d], m_rd[d]);
      end
    end
  endtask

  task automatic test_overflow();
    longint unsigned exp_data [ND];
    logic            exp_ovf1 [ND];
    exp_data[0] = 257; exp_data[1] = 1;    exp_data[2] = 255;
    exp_ovf1[0] = 1'b0; exp_ovf1[1] = 1'b1; exp_ovf1[2] = 1'b1;
    pulse_reset();
    cnt_en = 1'b1;
    evt = NE'(2);
    tick(257);
    cnt_en = 1'b0;
    evt = '0;
    take_snap();
    issue_read(1);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_data[d] !== exp_data[d] || o_ovf[d][1] !== exp_ovf1[d] || o_ovf[d] !== m_ovf[d] || o_data[d] !== m_rd[d]) begin
        fails++;
        $display("FAIL overflow d%0d: got data=%0d ovf=%0h, expected data=%0d ovf1=%0b (model ovf %0h)",
                 d, o_data[d], o_ovf[d], exp_data[d], exp_ovf1[d], m_ovf[d]);
      end
    end
  endtask

  task automatic test_snap_clr();
    pulse_reset();
    cnt_en = 1'b1;
    evt = NE'(4);
    tick(5);
    cnt_en = 1'b0;
    evt = '0;
    snap = 1'b1;
    clr = 1'b1;
    tick(1);
    snap = 1'b0;
    clr = 1'b0;
    issue_read(2);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_rv[d] !== 1'b1 || o_data[d] !== 64'd5) begin
        fails++;
        $display("FAIL snap_clr_first d%0d: got valid=%0b data=%0d, expected 1 5", d, o_rv[d], o_data[d]);
      end
    end
    cnt_en = 1'b1;
    evt = NE'(4);
    tick(3);
    cnt_en = 1'b0;
    evt = '0;
    take_snap();
    issue_read(2);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_rv[d] !== 1'b1 || o_data[d] !== 64'd3 || o_ovf[d] !== '0) begin
        fails++;
        $display("FAIL snap_clr_second d%0d: got valid=%0b data=%0d ovf=%0h, expected 1 3 0",
                 d, o_rv[d], o_data[d], o_ovf[d]);
      end
    end
  endtask

  task automatic test_err_stall();
    longint unsigned held [ND];
    int bad_idx;
    tick(1);
    bad_idx = $urandom_range(NE + 1, (1 << IW) - 1);
    issue_read(NE + 1);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_rv[d] !== 1'b1 || o_re[d] !== 1'b1 || o_data[d] !== 64'd0) begin
        fails++;
        $display("FAIL err_idx9 d%0d: got valid=%0b err=%0b data=%0h, expected 1 1 0", d, o_rv[d], o_re[d], o_data[d]);
      end
    end
    issue_read(bad_idx);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_re[d] !== 1'b1 || o_data[d] !== 64'd0) begin
        fails++;
        $display("FAIL err_idx%0d d%0d: got err=%0b data=%0h, expected 1 0", bad_idx, d, o_re[d], o_data[d]);
      end
    end
    tick(1);
    for (int d = 0; d < ND; d++) held[d] = m_sh[d][0];
    rsp_ready = 1'b0;
    issue_read(0);
    rd_req = 1'b1;
    rd_idx = IW'(2);
    for (int c = 0; c < 4; c++) begin
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (o_rv[d] !== 1'b1 || o_re[d] !== 1'b0 || o_data[d] !== held[d] || o_rdy[d] !== 1'b0) begin
          fails++;
          $display("FAIL stall c%0d d%0d: got valid=%0b err=%0b data=%0d rdy=%0b, expected 1 0 %0d 0",
                   c, d, o_rv[d], o_re[d], o_data[d], o_rdy[d], held[d]);
        end
      end
      tick(1);
    end
    rd_req = 1'b0;
    rsp_ready = 1'b1;
    tick(1);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_rv[d] !== 1'b0 || o_rdy[d] !== 1'b1) begin
        fails++;
        $display("FAIL stall_release d%0d: got valid=%0b rdy=%0b, expected 0 1", d, o_rv[d], o_rdy[d]);
      end
    end
  endtask

  task automatic test_disabled();
    longint unsigned saved [ND][NE+1];
    for (int d = 0; d < ND; d++)
      for (int i = 0; i <= NE; i++) saved[d][i] = m_live[d][i];
    cnt_en = 1'b0;
    evt = '1;
    tick(20);
    evt = '0;
    take_snap();
    for (int k = 0; k <= NE; k++) begin
      issue_read(k);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (o_rv[d] !== 1'b1 || o_data[d] !== saved[d][k]) begin
          fails++;
          $display("FAIL disabled idx%0d d%0d: got valid=%0b data=%0d, expected 1 %0d", k, d, o_rv[d], o_data[d], saved[d][k]);
        end
      end
    end
    tick(1);
    rsp_ready = 1'b0;
    issue_read(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_rv[d] !== 1'b0 || o_data[d] !== 64'd0 || o_rdy[d] !== 1'b1) begin
        fails++;
        $display("FAIL reset_midop d%0d: got valid=%0b data=%0h rdy=%0b, expected 0 0 1", d, o_rv[d], o_data[d], o_rdy[d]);
      end
    end
    take_snap();
    issue_read(2);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_data[d] !== 64'd0) begin
        fails++;
        $display("FAIL counts_lost d%0d: got data=%0d, expected 0", d, o_data[d]);
      end
    end
  endtask

  task automatic test_snap_during_read();
    longint unsigned s1 [ND][NE+1];
    longint unsigned l2 [ND][NE+1];
    int ks [2];
    pulse_reset();
    cnt_en = 1'b1;
    repeat (6) begin evt = NE'($urandom); tick(1); end
    cnt_en = 1'b0;
    evt = '0;
    take_snap();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i <= NE; i++) s1[d][i] = m_sh[d][i];
    cnt_en = 1'b1;
    repeat (5) begin evt = NE'($urandom); tick(1); end
    cnt_en = 1'b0;
    evt = '0;
    for (int d = 0; d < ND; d++)
      for (int i = 0; i <= NE; i++) l2[d][i] = m_live[d][i];
    ks[0] = $urandom_range(0, NE - 1);
    ks[1] = NE;
    for (int n = 0; n < 2; n++) begin
      snap = 1'b1;
      rd_req = 1'b1;
      rd_idx = IW'(ks[n]);
      tick(1);
      snap = 1'b0;
      rd_req = 1'b0;
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (o_rv[d] !== 1'b1 || o_data[d] !== s1[d][ks[n]]) begin
          fails++;
          $display("FAIL snap_in_read_old idx%0d d%0d: got valid=%0b data=%0d, expected 1 %0d",
                   ks[n], d, o_rv[d], o_data[d], s1[d][ks[n]]);
        end
      end
      issue_read(ks[n]);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (o_rv[d] !== 1'b1 || o_data[d] !== l2[d][ks[n]]) begin
          fails++;
          $display("FAIL snap_in_read_new idx%0d d%0d: got valid=%0b data=%0d, expected 1 %0d",
                   ks[n], d, o_rv[d], o_data[d], l2[d][ks[n]]);
        end
      end
      for (int d = 0; d < ND; d++)
        for (int i = 0; i <= NE; i++) s1[d][i] = l2[d][i];
    end
  endtask

  task automatic test_random();
    pulse_reset();
    repeat (400) begin
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (o_rv[d] !== m_rv[d] || o_rdy[d] !== (!m_rv[d] || rsp_ready) || o_ovf[d] !== m_ovf[d] ||
            (m_rv[d] && (o_data[d] !== m_rd[d] || o_re[d] !== m_re[d]))) begin
          fails++;
          $display("FAIL random d%0d: got valid=%0b rdy=%0b ovf=%0h err=%0b data=%0d, expected %0b %0b %0h %0b %0d",
                   d, o_rv[d], o_rdy[d], o_ovf[d], o_re[d], o_data[d],
                   m_rv[d], (!m_rv[d] || rsp_ready), m_ovf[d], m_re[d], m_rd[d]);
        end
      end
      cnt_en    = ($urandom_range(0, 3) != 0);
      evt       = NE'($urandom);
      clr       = ($urandom_range(0, 59) == 0);
      snap      = ($urandom_range(0, 7) == 0);
      rd_req    = $urandom_range(0, 1) == 1;
      rd_idx    = IW'($urandom_range(0, (1 << IW) - 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    cnt_en = 1'b0; evt = '0; clr = 1'b0; snap = 1'b0; rd_req = 1'b0; rsp_ready = 1'b1;
    tick(1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_count();
    test_overflow();
    test_snap_clr();
    test_err_stall();
    test_disabled();
    test_snap_during_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
